// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Decode-stage hazard and stall controller for the 5-stage int+float pipeline.
//   It detects load-use RAW hazards between the load in EX and the instruction
//   in ID. It also keeps a multi-cycle FP op (mul/div) in EX for FP_LAT cycles.
//   From these it drives the stall and bubble selects of the pipeline registers.
//
// Parameters
//   FP_LAT  cycles a multi-cycle FP op occupies EX (2..15)
//   WB_MEM  write-back source code that marks a load (data memory)
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk, rst_n                      clock; synchronous active-low reset
//   id_rs, id_rt, id_use_rs/rt      decode source registers and their use flags
//   id_float                        decode sources are in the float regfile
//   id_flush                        squash the decode instruction
//   ex_rwrite, ex_float, ex_wbsrc,  EX destination write, regfile and wb source,
//   ex_dst_reg, ex_fp_multi         EX destination register, EX multi-cycle FP op
//   ext_stall                       memory-wait freeze from the MEM stage
//   stall_front                     hold PC and IF/ID
//   stall_idex                      hold ID/EX
//   bubble_idex, bubble_exmem       load zero control into ID/EX, EX/MEM
//   fp_busy                         FP sequencer is in BUSY
//   fp_done                         FP op leaves EX at this edge
//   stall_cycles                    saturating count of stall_front cycles
module hazard_stall_ctrl #(
  parameter int FP_LAT = 4,
  parameter int WB_MEM = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_float,
  input  logic             id_flush,
  input  logic             ex_rwrite,
  input  logic             ex_float,
  input  logic [2:0]       ex_wbsrc,
  input  logic [4:0]       ex_dst_reg,
  input  logic             ex_fp_multi,
  input  logic             ext_stall,
  output logic             stall_front,
  output logic             stall_idex,
  output logic             bubble_idex,
  output logic             bubble_exmem,
  output logic             fp_busy,
  output logic             fp_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} fpState_t;

  // The first EX cycle is spent in IDLE, and the done cycle is the cnt==0 cycle.
  // So the counter starts two below the latency.
  localparam logic [3:0] CNT_INIT = 4'(FP_LAT - 2);
  localparam logic [2:0] WB_LOAD  = 3'(WB_MEM);

  fpState_t   state;
  fpState_t   stateNext;
  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic       fpStall;
  logic       fpDoneRaw;
  logic       loadUse;
  logic       rsHit;
  logic       rtHit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // FP occupancy sequencer: next state and FP stall/done
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    fpStall   = 1'b0;
    fpDoneRaw = 1'b0;
    case (state)
      IDLE: begin
        if (ex_fp_multi) begin
          fpStall   = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          fpStall = 1'b1;
          cntNext = cnt - 4'd1;
        end else if (!ext_stall) begin
          // A memory freeze at the final cycle keeps the op in EX until release.
          fpDoneRaw = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Load-use RAW hazard. Integer $0 is hard-wired, so it never hazards.
  // Float f0 is a real register and can hazard.
  always_comb begin
    rsHit   = id_use_rs && (id_rs == ex_dst_reg);
    rtHit   = id_use_rt && (id_rt == ex_dst_reg);
    loadUse = ex_rwrite && (ex_wbsrc == WB_LOAD) && (ex_float == id_float) &&
              (rsHit || rtHit) && (ex_float || (ex_dst_reg != 5'd0));
  end

  // Output priority: memory freeze, FP occupancy, load-use, flush.
  // While reset is held, every output is forced low.
  always_comb begin
    stall_front  = 1'b0;
    stall_idex   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    fp_busy      = 1'b0;
    fp_done      = 1'b0;
    if (rst_n) begin
      fp_busy = (state == BUSY);
      fp_done = fpDoneRaw;
      if (ext_stall) begin
        stall_front = 1'b1;
        stall_idex  = 1'b1;
      end else if (fpStall) begin
        stall_front  = 1'b1;
        stall_idex   = 1'b1;
        bubble_exmem = 1'b1;
      end else if (loadUse) begin
        // One bubble is enough: next cycle the load is in MEM and forwards.
        stall_front = 1'b1;
        bubble_idex = 1'b1;
      end else if (id_flush) begin
        bubble_idex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_front) begin
      stall_cycles <= satInc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int FP_LAT = 4;
  localparam int WB_MEM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_dst_reg;
  logic        id_use_rs, id_use_rt, id_float, id_flush;
  logic        ex_rwrite, ex_float, ex_fp_multi, ext_stall;
  logic [2:0]  ex_wbsrc;

  logic        stall_front, stall_idex, bubble_idex, bubble_exmem, fp_busy, fp_done;
  logic [15:0] stall_cycles;
  logic        satStallFront, satStallIdex, satBubbleIdex, satBubbleExmem, satFpBusy, satFpDone;
  logic [3:0]  satStallCycles;

  hazard_stall_ctrl #(.FP_LAT(FP_LAT), .WB_MEM(WB_MEM), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_float(id_float), .id_flush(id_flush),
    .ex_rwrite(ex_rwrite), .ex_float(ex_float), .ex_wbsrc(ex_wbsrc),
    .ex_dst_reg(ex_dst_reg), .ex_fp_multi(ex_fp_multi), .ext_stall(ext_stall),
    .stall_front(stall_front), .stall_idex(stall_idex), .bubble_idex(bubble_idex),
    .bubble_exmem(bubble_exmem), .fp_busy(fp_busy), .fp_done(fp_done),
    .stall_cycles(stall_cycles));

  hazard_stall_ctrl #(.FP_LAT(FP_LAT), .WB_MEM(WB_MEM), .CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_float(id_float), .id_flush(id_flush),
    .ex_rwrite(ex_rwrite), .ex_float(ex_float), .ex_wbsrc(ex_wbsrc),
    .ex_dst_reg(ex_dst_reg), .ex_fp_multi(ex_fp_multi), .ext_stall(ext_stall),
    .stall_front(satStallFront), .stall_idex(satStallIdex), .bubble_idex(satBubbleIdex),
    .bubble_exmem(satBubbleExmem), .fp_busy(satFpBusy), .fp_done(satFpDone),
    .stall_cycles(satStallCycles));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an FP op is tracked by how many cycles it has been in EX.
  bit mIn   = 0;
  int mPos  = 0;
  int mCnt16 = 0;
  int mCnt4  = 0;

  always @(negedge clk) begin
    int  pos;
    bit  active, fs, fd, fb, lu;
    bit  eF, eI, eBI, eBE;
    if (!rst_n) begin
      check("rstFront", {31'd0, stall_front}, 0);
      check("rstIdex", {31'd0, stall_idex}, 0);
      check("rstBubIdex", {31'd0, bubble_idex}, 0);
      check("rstBubExmem", {31'd0, bubble_exmem}, 0);
      check("rstBusy", {31'd0, fp_busy}, 0);
      check("rstDone", {31'd0, fp_done}, 0);
      check("rstSatFront", {31'd0, satStallFront}, 0);
      mIn = 0; mPos = 0; mCnt16 = 0; mCnt4 = 0;
    end else begin
      check("stallCycles", {16'd0, stall_cycles}, mCnt16);
      check("satStallCycles", {28'd0, satStallCycles}, mCnt4);
      pos    = mIn ? mPos : (ex_fp_multi ? 1 : 0);
      active = (pos > 0);
      fs     = active && (pos < FP_LAT);
      fb     = (pos >= 2);
      fd     = active && (pos >= FP_LAT) && !ext_stall;
      lu     = ex_rwrite && (ex_wbsrc == WB_MEM) && (ex_float == id_float) &&
               ((id_use_rs && id_rs == ex_dst_reg) || (id_use_rt && id_rt == ex_dst_reg)) &&
               (ex_float || ex_dst_reg != 0);
      eF = 0; eI = 0; eBI = 0; eBE = 0;
      if (ext_stall) begin eF = 1; eI = 1; end
      else if (fs) begin eF = 1; eI = 1; eBE = 1; end
      else if (lu) begin eF = 1; eBI = 1; end
      else if (id_flush) eBI = 1;
      check("stallFront", {31'd0, stall_front}, {31'd0, eF});
      check("stallIdex", {31'd0, stall_idex}, {31'd0, eI});
      check("bubbleIdex", {31'd0, bubble_idex}, {31'd0, eBI});
      check("bubbleExmem", {31'd0, bubble_exmem}, {31'd0, eBE});
      check("fpBusy", {31'd0, fp_busy}, {31'd0, fb});
      check("fpDone", {31'd0, fp_done}, {31'd0, fd});
      check("satFront", {31'd0, satStallFront}, {31'd0, eF});
      if (active && !fd) begin mIn = 1; mPos = pos + 1; end
      else begin mIn = 0; mPos = 0; end
      if (eF) begin
        mCnt16 = (mCnt16 < 65535) ? mCnt16 + 1 : 65535;
        mCnt4  = (mCnt4 < 15) ? mCnt4 + 1 : 15;
      end
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_float = 0; id_flush = 0;
    ex_rwrite = 0; ex_float = 0; ex_wbsrc = 0; ex_dst_reg = 0; ex_fp_multi = 0;
    ext_stall = 0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic setLoad(input bit flt, input logic [4:0] dst);
    ex_rwrite = 1; ex_float = flt; ex_wbsrc = 3'(WB_MEM); ex_dst_reg = dst;
  endtask

  task automatic checkOuts(input string name, input bit f, input bit i, input bit bi,
                           input bit be, input bit b, input bit d);
    check({name, ".front"}, {31'd0, stall_front}, {31'd0, f});
    check({name, ".idex"}, {31'd0, stall_idex}, {31'd0, i});
    check({name, ".bubIdex"}, {31'd0, bubble_idex}, {31'd0, bi});
    check({name, ".bubExmem"}, {31'd0, bubble_exmem}, {31'd0, be});
    check({name, ".busy"}, {31'd0, fp_busy}, {31'd0, b});
    check({name, ".done"}, {31'd0, fp_done}, {31'd0, d});
  endtask

  initial begin
    rst_n = 0;
    clr();
    nextCyc();
    sample();
    checkOuts("inReset", 0, 0, 0, 0, 0, 0);
    nextCyc(); rst_n = 1;
    sample();
    check("postRstCycles", {16'd0, stall_cycles}, 0);
    checkOuts("postRst", 0, 0, 0, 0, 0, 0);

    // lw $5 in EX, add reads $5: one bubble, then clear
    nextCyc(); clr(); setLoad(0, 5); id_rs = 5; id_use_rs = 1;
    sample(); checkOuts("loadUse", 1, 0, 1, 0, 0, 0);
    nextCyc(); clr(); id_rs = 5; id_use_rs = 1;
    sample(); checkOuts("loadUseNext", 0, 0, 0, 0, 0, 0);

    // lw $0 -> add rs=0: no hazard
    nextCyc(); clr(); setLoad(0, 0); id_rs = 0; id_use_rs = 1;
    sample(); checkOuts("zeroReg", 0, 0, 0, 0, 0, 0);

    // float load f0 -> float op reads f0 through rt
    nextCyc(); clr(); setLoad(1, 0); id_float = 1; id_rt = 0; id_use_rt = 1;
    sample(); checkOuts("floatF0", 1, 0, 1, 0, 0, 0);

    // int load r7 -> float op reads f7
    nextCyc(); clr(); setLoad(0, 7); id_float = 1; id_rs = 7; id_use_rs = 1;
    sample(); checkOuts("intToFloat", 0, 0, 0, 0, 0, 0);

    // flush alone, and flush under load-use
    nextCyc(); clr(); id_flush = 1;
    sample(); checkOuts("flush", 0, 0, 1, 0, 0, 0);
    nextCyc(); clr(); id_flush = 1; setLoad(0, 9); id_rt = 9; id_use_rt = 1;
    sample(); checkOuts("flushLoadUse", 1, 0, 1, 0, 0, 0);

    // single FP op
    for (int k = 1; k <= 4; k++) begin
      nextCyc(); clr(); ex_fp_multi = 1;
      sample(); checkOuts("fpSingle", k < 4, k < 4, 0, k < 4, k >= 2, k == 4);
    end
    nextCyc(); clr();
    sample(); checkOuts("fpAfter", 0, 0, 0, 0, 0, 0);

    // ext_stall held at the final FP cycle for two cycles
    for (int k = 1; k <= 6; k++) begin
      nextCyc(); clr(); ex_fp_multi = 1; ext_stall = (k == 4 || k == 5);
      sample(); checkOuts("fpExt", k <= 5, k <= 5, 0, k <= 3, k >= 2, k == 6);
    end

    // back-to-back FP ops
    for (int k = 1; k <= 8; k++) begin
      nextCyc(); clr(); ex_fp_multi = 1;
      sample(); checkOuts("fpB2B", (k % 4) != 0, (k % 4) != 0, 0, (k % 4) != 0,
                          (k % 4) != 1, (k % 4) == 0);
    end

    // reset mid-BUSY
    for (int k = 1; k <= 2; k++) begin
      nextCyc(); clr(); ex_fp_multi = 1;
      sample();
    end
    nextCyc(); rst_n = 0;
    sample(); checkOuts("rstMidBusy", 0, 0, 0, 0, 0, 0);
    nextCyc(); rst_n = 1; clr();
    sample(); checkOuts("afterRstBusy", 0, 0, 0, 0, 0, 0);
    check("afterRstCycles", {16'd0, stall_cycles}, 0);

    // saturation: 20 stall cycles
    for (int k = 0; k < 20; k++) begin
      nextCyc(); clr(); ext_stall = 1;
    end
    nextCyc(); clr();
    sample();
    check("sat4", {28'd0, satStallCycles}, 15);
    check("noSat16", {16'd0, stall_cycles}, 20);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nextCyc();
      rst_n       = ($urandom_range(0, 199) != 0);
      ext_stall   = ($urandom_range(0, 7) == 0);
      ex_fp_multi = ($urandom_range(0, 5) == 0);
      ex_rwrite   = $urandom_range(0, 1);
      ex_float    = $urandom_range(0, 1);
      ex_wbsrc    = ($urandom_range(0, 1) == 1) ? 3'(WB_MEM) : 3'($urandom_range(0, 7));
      ex_dst_reg  = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = $urandom_range(0, 1);
      id_use_rt   = $urandom_range(0, 1);
      id_float    = $urandom_range(0, 1);
      id_flush    = ($urandom_range(0, 5) == 0);
    end
    nextCyc(); rst_n = 1; clr();
    sample();
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
